// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO over a valid/ready write port.
// Frame format (length, parity, stop bits, baud divisor) is captured when a byte is popped.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  // Write port: a byte transfers on a rising edge where s_valid && s_ready.
  // s_ready depends only on the FIFO count and reset, never on s_valid.
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic [3:0]           data_length,
  input  logic [1:0]           parity_type,
  input  logic                 stop_bits,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 serial_data_out,
  output logic                 busy,
  output logic                 frame_done,
  output logic [CNT_WIDTH-1:0] fifo_count,
  output logic [2:0]           dbg_state
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic [7:0]           r_shift;
  logic [DIV_WIDTH-1:0] r_baud_cnt;
  logic [2:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic [2:0]           r_len_m1;
  logic                 r_par_en;
  logic                 r_par_bit;
  logic                 r_two_stop;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_line;

  state_t               w_state_nxt;
  logic [7:0]           w_shift_nxt;
  logic [DIV_WIDTH-1:0] w_baud_nxt;
  logic [2:0]           w_bit_nxt;
  logic                 w_stop_nxt;
  logic                 w_line_nxt;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_done;
  logic                 w_tick;
  logic                 w_empty;
  logic [7:0]           w_head;
  logic [2:0]           w_len_m1;
  logic [7:0]           w_mask;

  assign w_empty  = (r_count == '0);
  assign s_ready  = (r_count < CNT_WIDTH'(FIFO_DEPTH)) && !reset;
  assign w_push   = s_valid && s_ready;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_tick   = (r_baud_cnt == r_div);

  // Out-of-range lengths are clamped into 5..8 before being stored as length-1.
  assign w_len_m1 = (data_length < 4'd5) ? 3'd4 :
                    (data_length > 4'd8) ? 3'd7 : 3'(data_length - 4'd1);
  assign w_mask   = 8'hFF >> (3'd7 - w_len_m1);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_baud_nxt  = r_baud_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_stop_nxt  = r_stop_cnt;
    w_line_nxt  = r_line;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_line_nxt = 1'b1;
        if (!w_empty) w_pop = 1'b1;
      end
      S_START: begin
        if (w_tick) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_line_nxt  = r_shift[0];
          w_state_nxt = S_DATA;
        end else begin
          w_baud_nxt = r_baud_cnt + DIV_WIDTH'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (r_bit_cnt == r_len_m1) begin
            w_stop_nxt = 1'b0;
            if (r_par_en) begin
              w_line_nxt  = r_par_bit;
              w_state_nxt = S_PARITY;
            end else begin
              w_line_nxt  = 1'b1;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_line_nxt  = r_shift[1];
            w_bit_nxt   = r_bit_cnt + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + DIV_WIDTH'(1);
        end
      end
      S_PARITY: begin
        if (w_tick) begin
          w_baud_nxt  = '0;
          w_stop_nxt  = 1'b0;
          w_line_nxt  = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_baud_nxt = r_baud_cnt + DIV_WIDTH'(1);
        end
      end
      S_STOP: begin
        if (w_tick) begin
          w_baud_nxt = '0;
          if (r_stop_cnt == r_two_stop) begin
            w_done = 1'b1;
            // A queued byte starts its frame on the very next bit boundary.
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_line_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud_cnt + DIV_WIDTH'(1);
        end
      end
      default: begin
        w_line_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_pop) begin
      w_shift_nxt = w_head;
      w_baud_nxt  = '0;
      w_bit_nxt   = '0;
      w_stop_nxt  = 1'b0;
      w_line_nxt  = 1'b0;
      w_state_nxt = S_START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_line     <= 1'b1;
      r_len_m1   <= 3'd7;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_div      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_stop_cnt <= w_stop_nxt;
      r_line     <= w_line_nxt;
      if (w_pop) begin
        r_len_m1   <= w_len_m1;
        r_par_en   <= !parity_type[1];
        r_par_bit  <= (^(w_head & w_mask)) ^ (parity_type == 2'd1);
        r_two_stop <= stop_bits;
        r_div      <= baud_div;
      end
    end
  end

  assign serial_data_out = r_line;
  assign busy            = (r_state != S_IDLE);
  assign frame_done      = w_done;
  assign fifo_count      = r_count;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: drivers push bytes into an expected queue, a cycle-level
// monitor models FIFO occupancy and frame timing and compares every output each cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int CW    = 4;

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          s_valid     = 1'b0;
  logic [7:0]    s_data      = '0;
  logic [3:0]    data_length = 4'd8;
  logic [1:0]    parity_type = 2'd0;
  logic          stop_bits   = 1'b0;
  logic [DW-1:0] baud_div    = 16'd3;
  logic          s_ready;
  logic          serial_data_out;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] fifo_count;
  logic [2:0]    dbg_state;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .data_length(data_length), .parity_type(parity_type), .stop_bits(stop_bits),
    .baud_div(baud_div), .serial_data_out(serial_data_out), .busy(busy),
    .frame_done(frame_done), .fifo_count(fifo_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Entry layout: {baud_div[15:0], stop_bits, parity_type[1:0], data_length[3:0], data[7:0]}
  logic [30:0] exp_q[$];
  int          n_acc = 0;

  // reference model state (owned by the monitor)
  int          n_seen    = 0;
  int          model_cnt = 0;
  bit          in_frame  = 0;
  bit          prev_rst  = 1;
  int          cyc       = 0;
  int          fr_total  = 0;
  int          fr_div1   = 1;
  logic [11:0] fr_bits;
  int          pushes;
  int          popped;
  logic        exp_line;
  int          done_cnt  = 0;
  int          max_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line level of each bit slot of one frame, from the frame-format rules.
  function automatic void build_frame(input logic [30:0] e);
    logic [7:0] d;
    int len;
    int ones;
    int nb;
    d   = e[7:0];
    len = (e[11:8] < 5) ? 5 : (e[11:8] > 8) ? 8 : int'(e[11:8]);
    nb = 0;
    ones = 0;
    fr_bits = '1;
    fr_bits[nb] = 1'b0; nb++;
    for (int i = 0; i < len; i++) begin
      fr_bits[nb] = d[i]; nb++;
      ones += int'(d[i]);
    end
    if (e[13:12] < 2) begin
      fr_bits[nb] = ((ones % 2) == 1) ^ (e[13:12] == 2'd1); nb++;
    end
    fr_bits[nb] = 1'b1; nb++;
    if (e[14]) begin fr_bits[nb] = 1'b1; nb++; end
    fr_div1  = int'(e[30:15]) + 1;
    fr_total = nb * fr_div1;
  endfunction

  // monitor / scoreboard
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (prev_rst) begin
        in_frame  = 0;
        model_cnt = 0;
        exp_q.delete();
        n_seen    = n_acc;
      end else begin
        pushes = n_acc - n_seen;
        n_seen = n_acc;
        popped = 0;
        if (!in_frame && model_cnt > 0) begin
          build_frame(exp_q.pop_front());
          in_frame = 1;
          cyc      = 0;
          popped   = 1;
        end
        model_cnt = model_cnt + pushes - popped;
      end
      exp_line = in_frame ? fr_bits[cyc / fr_div1] : 1'b1;
      check("cycle{line,busy,done,ready,count}",
            64'({serial_data_out, busy, frame_done, s_ready, fifo_count}),
            64'({exp_line, in_frame, (in_frame && cyc == fr_total - 1),
                 (!reset && model_cnt < DEPTH), CW'(model_cnt)}));
      if (frame_done === 1'b1) done_cnt++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (in_frame) begin
        cyc++;
        if (cyc == fr_total) in_frame = 0;
      end
      prev_rst = reset;
    end
  end

  // driver tasks
  task automatic set_cfg(input int div, input int len, input int par, input int stp);
    baud_div    = DW'(div);
    data_length = 4'(len);
    parity_type = 2'(par);
    stop_bits   = 1'(stp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int  waited = 0;
    bit  fin    = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (!fin) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        exp_q.push_back({baud_div, stop_bits, parity_type, data_length, b});
        n_acc++;
        fin = 1;
      end else begin
        waited++;
        if (waited > 5000) begin
          n_tests++;
          n_fail++;
          $display("FAIL push_timeout: s_ready low for %0d cycles at %0t", waited, $time);
          fin = 1;
        end
      end
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((in_frame || model_cnt != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("idle_within_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic start_phase();
    done_cnt = 0;
    max_cnt  = 0;
  endtask

  task automatic send_one(input int div, input int len, input int par, input int stp,
                          input logic [7:0] b);
    set_cfg(div, len, par, stp);
    start_phase();
    push_byte(b);
    wait_idle(2000);
    check("single_frame_done_pulses", 64'(done_cnt), 64'd1);
  endtask

  initial begin : stimulus
    int nb;
    int gap;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    send_one(3, 8, 0, 0, 8'h81);
    send_one(3, 8, 1, 0, 8'h83);
    send_one(3, 8, 0, 0, 8'h83);
    send_one(3, 8, 2, 0, 8'h03);
    send_one(3, 5, 3, 0, 8'hFF);
    send_one(2, 2, 2, 0, 8'hFF);
    send_one(1, 12, 0, 0, 8'h5A);
    send_one(3, 8, 0, 1, 8'h3C);
    send_one(0, 7, 1, 1, 8'h6B);

    // four back-to-back pushes into an empty FIFO
    set_cfg(1, 8, 0, 0);
    start_phase();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
    wait_idle(2000);
    check("burst_peak_count", 64'(max_cnt), 64'd3);
    check("burst_done_pulses", 64'(done_cnt), 64'd4);

    // overfill: FIFO_DEPTH+2 bytes with a slow bit rate
    set_cfg(30, 8, 0, 0);
    start_phase();
    for (int i = 0; i < DEPTH + 2; i++) push_byte(8'(8'h10 + i));
    wait_idle(20000);
    check("full_peak_count", 64'(max_cnt), 64'(DEPTH));
    check("full_done_pulses", 64'(done_cnt), 64'(DEPTH + 2));

    // config changed after the pop must not affect the frame in flight
    set_cfg(2, 8, 0, 0);
    push_byte(8'h96);
    nb = 0;
    while (!in_frame && nb < 100) begin @(negedge clk); nb++; end
    check("latch_frame_started", 64'(in_frame), 64'd1);
    set_cfg(5, 5, 1, 1);
    wait_idle(2000);
    send_one(5, 5, 1, 1, 8'h96);

    // reset for one cycle in the middle of the data bits, with bytes still queued
    set_cfg(3, 8, 0, 0);
    push_byte(8'hC3);
    push_byte(8'h11);
    push_byte(8'h22);
    repeat (20) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    wait_idle(2000);
    send_one(3, 8, 0, 0, 8'hA5);

    // randomized frames and bursts
    for (int it = 0; it < 30; it++) begin
      set_cfg($urandom_range(0, 4), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 1));
      start_phase();
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) begin @(posedge clk); #1; end
        push_byte(8'($urandom_range(0, 255)));
      end
      wait_idle(5000);
      check("random_done_pulses", 64'(done_cnt), 64'(nb));
    end

    check("expected_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
